gcd_stein_engine: RTL
=====================

// Module: gcd_stein_engine
// PURPOSE
//  Parametrised binary (Stein) GCD engine; successor of the 16-bit subtractive gcd unit.
//  - Generic WIDTH; valid/ready handshakes on request and result.
//  - Zero-operand handling, status flag, iteration counter.
//  - Sits between operand source (switches/UART/CPU reg) and display/consumer logic.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=2)
//  CNT_W  $clog2(4*WIDTH+4)  localparam; width of out_cycles
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      reset; synchronous, active-high
//  in_valid    in   1      request operands valid
//  in_ready    out  1      engine idle, can accept request
//  in_a        in   WIDTH  operand A (unsigned)
//  in_b        in   WIDTH  operand B (unsigned)
//  out_valid   out  1      result valid; held until accepted
//  out_ready   in   1      consumer accepts result
//  out_gcd     out  WIDTH  gcd(A,B)
//  out_zero    out  1      both operands were 0 (out_gcd=0)
//  out_cycles  out  CNT_W  cycles spent from CHECK entry to DONE entry
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; out_valid=0; out_gcd=0; out_zero=0; out_cycles=0; internal regs 0.
//  FSM: IDLE -> CHECK -> TWOS -> REDUCE -> DONE -> IDLE. One state step per clk.
//  - IDLE: in_ready=1. in_valid&in_ready at edge: latch a=in_a, b=in_b, k=0, cnt=0 -> CHECK.
//  - CHECK: a==0|b==0 -> gcd=a|b, zero=(a==0&b==0) -> DONE. Else -> TWOS.
//  - TWOS: a[0]==0 & b[0]==0 -> a>>=1, b>>=1, k++, stay. Else -> REDUCE (no data change).
//  - REDUCE, priority order, one action per cycle:
//    a even -> a>>=1; elif b even -> b>>=1; elif a==b -> gcd=a<<k -> DONE;
//    elif a>b -> a=a-b; else b=b-a.
//  - DONE: out_valid=1, outputs stable. out_valid&out_ready at edge -> IDLE.
//  cnt increments every cycle in CHECK/TWOS/REDUCE; copied to out_cycles on DONE entry.
//  Latency: out_valid rises exactly out_cycles edges after the accepting edge; out_cycles <= 4*WIDTH+2.
//  Outputs out_gcd/out_zero/out_cycles update only on DONE entry; hold their value through IDLE until the next result.
//  in_ready=0 outside IDLE; in_valid while busy is ignored, not queued.
//  Result accept and new-request accept never share a cycle; in_ready returns the cycle after the out handshake.
//  out_valid asserted with out_ready=0: hold indefinitely, no data change.
//  Arithmetic: all unsigned, WIDTH bits; a>b in REDUCE, so subtraction never underflows.
//  k width $clog2(WIDTH+1); a<<k never overflows because the result <= min(A,B).
//  rst mid-operation: abort, discard operands, full reset values next cycle.
//  Operand A is not swapped; gcd(A,B)==gcd(B,A) must hold for every result.
// STRUCTURE
//  gcd_pkg: state enum (IDLE,CHECK,TWOS,REDUCE,DONE) and the CNT_W/K_W width functions.
//  Split per team practice:
//  - gcd_stein_datapath: a/b/k/cnt registers, shifters, comparator, subtractor, result regs.
//    Exports a_even, b_even, a_eq_b, a_gt_b, any_zero.
//  - FSM/handshake logic stays in gcd_stein_engine top.
// TESTING (WIDTH=16 unless noted)
//  1. (48,18): out_gcd=6, out_zero=0, out_cycles=9; out_valid 9 edges after accept.
//  2. (0,35) -> 35, cycles=1. (35,0) -> 35. (0,0) -> gcd=0, out_zero=1, cycles=1.
//  3. (65535,1) -> 1, cycles=33. (7,7) -> 7, cycles=3. (1024,4096) -> 1024.
//  4. Backpressure: hold out_ready=0 for 20 cycles; outputs stable; in_ready=0 throughout.
//     Assert in_valid during busy: request ignored. Release: in_ready=1 one cycle after the out handshake.
//  5. rst pulse while in REDUCE on (65535,1): next cycle IDLE, all outputs at reset values.
//     The next request (12,8) returns 4.
//  6. Random: 10k pairs at WIDTH=8 and WIDTH=32 against a reference model, checking gcd and zero.
//     Random in_valid/out_ready; assert out_cycles <= 4*WIDTH+2.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and width helpers for the binary (Stein) GCD engine.
// Width helpers are constant functions so they can size ports from WIDTH.
package gcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_TWOS,
        S_REDUCE,
        S_DONE
    } state_t;

    // Cycle counter width: worst case is 4*WIDTH+2 cycles from CHECK to DONE.
    function automatic int cnt_w(input int width);
        return $clog2(4 * width + 4);
    endfunction

    // Width of the common power-of-two exponent k (0..WIDTH).
    function automatic int k_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/gcd_stein_datapath.sv
// Operand, exponent, cycle-count and result registers for the Stein GCD engine.
// Sequencing comes from the engine FSM via one-hot-ish strobes; status flags go back.
module gcd_stein_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int CNT_W = cnt_w(WIDTH),
    localparam int K_W   = k_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_cnt_en,
    input  logic             i_shift_both,
    input  logic             i_shift_a,
    input  logic             i_shift_b,
    input  logic             i_sub,
    input  logic             i_capture,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_a_even,
    output logic             o_b_even,
    output logic             o_a_eq_b,
    output logic             o_a_gt_b,
    output logic             o_any_zero,
    output logic [WIDTH-1:0] o_gcd,
    output logic             o_zero,
    output logic [CNT_W-1:0] o_cycles
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [K_W-1:0]   r_k;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_gcd;
    logic             r_zero;
    logic [CNT_W-1:0] r_cycles;

    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [K_W-1:0]   w_k_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_both_zero;

    assign o_a_even    = ~r_a[0];
    assign o_b_even    = ~r_b[0];
    assign o_a_eq_b    = (r_a == r_b);
    assign o_a_gt_b    = (r_a > r_b);
    assign o_any_zero  = (r_a == '0) || (r_b == '0);
    assign w_both_zero = (r_a == '0) && (r_b == '0);

    // One subtractor: larger minus smaller, so the result never underflows.
    assign w_diff    = o_a_gt_b ? (r_a - r_b) : (r_b - r_a);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Capture happens either from CHECK (an operand is zero, gcd = a|b) or from
    // REDUCE on a==b (both nonzero, gcd = a<<k); the zero flag selects which.
    assign w_result = o_any_zero ? (r_a | r_b) : (r_a << r_k);

    always_comb begin
        w_a_nxt   = r_a;
        w_b_nxt   = r_b;
        w_k_nxt   = r_k;
        w_cnt_nxt = r_cnt;
        if (i_load) begin
            w_a_nxt   = i_a;
            w_b_nxt   = i_b;
            w_k_nxt   = '0;
            w_cnt_nxt = '0;
        end else begin
            if (i_cnt_en) begin
                w_cnt_nxt = w_cnt_inc;
            end
            if (i_shift_both) begin
                w_a_nxt = r_a >> 1;
                w_b_nxt = r_b >> 1;
                w_k_nxt = r_k + K_W'(1);
            end
            if (i_shift_a) begin
                w_a_nxt = r_a >> 1;
            end
            if (i_shift_b) begin
                w_b_nxt = r_b >> 1;
            end
            if (i_sub) begin
                if (o_a_gt_b) begin
                    w_a_nxt = w_diff;
                end else begin
                    w_b_nxt = w_diff;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_k   <= '0;
            r_cnt <= '0;
        end else begin
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_k   <= w_k_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // The capturing cycle itself counts, hence the incremented count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gcd    <= '0;
            r_zero   <= 1'b0;
            r_cycles <= '0;
        end else if (i_capture) begin
            r_gcd    <= w_result;
            r_zero   <= w_both_zero;
            r_cycles <= w_cnt_inc;
        end
    end

    assign o_gcd    = r_gcd;
    assign o_zero   = r_zero;
    assign o_cycles = r_cycles;

endmodule

// File: rtl/gcd_stein_engine.sv
// Binary (Stein) GCD engine with valid/ready request and result handshakes.
// FSM and handshake logic live here; arithmetic lives in gcd_stein_datapath.
module gcd_stein_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_cycles
);

    state_t r_state;
    state_t w_next;

    logic w_load;
    logic w_cnt_en;
    logic w_shift_both;
    logic w_shift_a;
    logic w_shift_b;
    logic w_sub;
    logic w_capture;
    logic w_a_even;
    logic w_b_even;
    logic w_a_eq_b;
    logic w_a_gt_b;
    logic w_any_zero;

    gcd_stein_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_cnt_en     (w_cnt_en),
        .i_shift_both (w_shift_both),
        .i_shift_a    (w_shift_a),
        .i_shift_b    (w_shift_b),
        .i_sub        (w_sub),
        .i_capture    (w_capture),
        .i_a          (in_a),
        .i_b          (in_b),
        .o_a_even     (w_a_even),
        .o_b_even     (w_b_even),
        .o_a_eq_b     (w_a_eq_b),
        .o_a_gt_b     (w_a_gt_b),
        .o_any_zero   (w_any_zero),
        .o_gcd        (out_gcd),
        .o_zero       (out_zero),
        .o_cycles     (out_cycles)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_cnt_en     = 1'b0;
        w_shift_both = 1'b0;
        w_shift_a    = 1'b0;
        w_shift_b    = 1'b0;
        w_sub        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_cnt_en = 1'b1;
                if (w_any_zero) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end else begin
                    w_next = S_TWOS;
                end
            end
            S_TWOS: begin
                w_cnt_en = 1'b1;
                if (w_a_even && w_b_even) begin
                    w_shift_both = 1'b1;
                end else begin
                    w_next = S_REDUCE;
                end
            end
            S_REDUCE: begin
                w_cnt_en = 1'b1;
                if (w_a_even) begin
                    w_shift_a = 1'b1;
                end else if (w_b_even) begin
                    w_shift_b = 1'b1;
                end else if (w_a_eq_b) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end else begin
                    w_sub = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

endmodule
